// File: rtl/ether_rx_framer_if.sv
// Bundle between the RMII receive pins, the framer and the downstream payload
// consumer. The master side is the framer itself. The slave side is the
// environment: the PHY drives crsdv/rxd, and the consumer takes the beat
// stream and the frame status.
//
// Beat handshake: axiov is a pure valid with no ready. A beat (axiod, axiol)
// is transferred on every cycle in which axiov is high. axiov is high for
// exactly one cycle per beat. axiol is only ever high together with axiov.
// frame_done is a one-cycle strobe. frame_len and err_* are meaningful only
// while it is high, and the err_* flags are 0 in every other cycle.
interface ether_rx_framer_if #(
    parameter int OUT_WIDTH = 8
);
    logic                 crsdv;
    logic [1:0]           rxd;
    logic                 axiov;
    logic [OUT_WIDTH-1:0] axiod;
    logic                 axiol;
    logic                 frame_done;
    logic [15:0]          frame_len;
    logic                 err_preamble;
    logic                 err_runt;
    logic                 err_long;
    logic                 err_align;
    logic [2:0]           dbg_state;

    modport master (
        input  crsdv, rxd,
        output axiov, axiod, axiol, frame_done, frame_len,
        output err_preamble, err_runt, err_long, err_align, dbg_state
    );

    modport slave (
        output crsdv, rxd,
        input  axiov, axiod, axiol, frame_done, frame_len,
        input  err_preamble, err_runt, err_long, err_align, dbg_state
    );
endinterface

// File: rtl/ether_rx_framer.sv
// RMII receive framer. It hunts for preamble/SFD, packs payload dibits
// LSB-first into OUT_WIDTH-bit beats, and holds one beat back so that the
// final beat of a frame can carry axiol. It also reports length and error
// status once per frame. dbg_state exposes the FSM state encoding.
module ether_rx_framer #(
    parameter int OUT_WIDTH       = 8,
    parameter int PREAMBLE_MIN    = 8,
    parameter int MIN_FRAME_BYTES = 64,
    parameter int MAX_FRAME_BYTES = 1522
) (
    input  logic              clk,
    input  logic              rst,
    ether_rx_framer_if.master bus
);
    localparam int DPB = OUT_WIDTH / 2;
    localparam int PW  = (PREAMBLE_MIN < 1) ? 1 : $clog2(PREAMBLE_MIN + 1);
    localparam logic [PW-1:0] PCNT_MAX  = PW'(PREAMBLE_MIN);
    localparam logic [1:0]    BEAT_LAST = 2'(DPB - 1);
    localparam logic [15:0]   MAX_LEN   = 16'(MAX_FRAME_BYTES);
    localparam logic [15:0]   MIN_LEN   = 16'(MIN_FRAME_BYTES);

    typedef enum logic [2:0] {
        SYNC     = 3'd0,
        IDLE     = 3'd1,
        PREAMBLE = 3'd2,
        DATA     = 3'd3,
        DROP     = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [PW-1:0]        pcnt_q, pcnt_d;
    logic [15:0]          byte_cnt_q, byte_cnt_d;
    logic [1:0]           dcnt_q, dcnt_d;      // dibit position within the current byte
    logic [1:0]           bcnt_q, bcnt_d;      // dibit position within the current beat
    logic [OUT_WIDTH-1:0] shreg_q, shreg_d;
    logic [OUT_WIDTH-1:0] hold_q, hold_d;
    logic                 hold_vld_q, hold_vld_d;
    logic                 axiov_q, axiov_d;
    logic [OUT_WIDTH-1:0] axiod_q, axiod_d;
    logic                 axiol_q, axiol_d;
    logic                 frame_done_q, frame_done_d;
    logic [15:0]          frame_len_q, frame_len_d;
    logic                 err_pre_q, err_pre_d;
    logic                 err_runt_q, err_runt_d;
    logic                 err_long_q, err_long_d;
    logic                 err_align_q, err_align_d;
    logic [OUT_WIDTH-1:0] sh_next;
    logic                 beat_done;
    logic                 byte_done;

    // Next-state and next-output computation for the receive FSM.
    always_comb begin
        state_d      = state_q;
        pcnt_d       = pcnt_q;
        byte_cnt_d   = byte_cnt_q;
        dcnt_d       = dcnt_q;
        bcnt_d       = bcnt_q;
        shreg_d      = shreg_q;
        hold_d       = hold_q;
        hold_vld_d   = hold_vld_q;
        axiov_d      = 1'b0;
        axiod_d      = axiod_q;
        axiol_d      = 1'b0;
        frame_done_d = 1'b0;
        frame_len_d  = frame_len_q;
        err_pre_d    = 1'b0;
        err_runt_d   = 1'b0;
        err_long_d   = 1'b0;
        err_align_d  = 1'b0;
        // New dibits enter at the top, so the earliest one ends up in [1:0].
        sh_next   = (shreg_q >> 2) | (OUT_WIDTH'(bus.rxd) << (OUT_WIDTH - 2));
        beat_done = (bcnt_q == BEAT_LAST);
        byte_done = (dcnt_q == 2'd3);

        case (state_q)
            SYNC: begin
                if (!bus.crsdv) state_d = IDLE;
            end
            IDLE: begin
                if (bus.crsdv) begin
                    if (bus.rxd == 2'b01) begin
                        state_d = PREAMBLE;
                        pcnt_d  = PW'(1);
                    end else if (bus.rxd != 2'b00) begin
                        state_d = DROP;
                    end
                end
            end
            PREAMBLE: begin
                if (!bus.crsdv) begin
                    state_d = IDLE;
                end else if (bus.rxd == 2'b01) begin
                    if (pcnt_q < PCNT_MAX) pcnt_d = pcnt_q + PW'(1);
                end else if (bus.rxd == 2'b11 && pcnt_q >= PCNT_MAX) begin
                    state_d    = DATA;
                    byte_cnt_d = 16'd0;
                    dcnt_d     = 2'd0;
                    bcnt_d     = 2'd0;
                    shreg_d    = '0;
                    hold_vld_d = 1'b0;
                end else begin
                    frame_done_d = 1'b1;
                    err_pre_d    = 1'b1;
                    frame_len_d  = 16'd0;
                    state_d      = DROP;
                end
            end
            DATA: begin
                if (!bus.crsdv) begin
                    // Normal end: flush the held beat and drop any partial beat.
                    if (hold_vld_q) begin
                        axiov_d = 1'b1;
                        axiol_d = 1'b1;
                        axiod_d = hold_q;
                    end
                    hold_vld_d   = 1'b0;
                    frame_done_d = 1'b1;
                    frame_len_d  = byte_cnt_q;
                    err_runt_d   = (byte_cnt_q < MIN_LEN);
                    err_align_d  = (bcnt_q != 2'd0) || (dcnt_q != 2'd0);
                    state_d      = IDLE;
                end else if (byte_done && byte_cnt_q == MAX_LEN) begin
                    // Overflow: the completing byte is discarded with its beat.
                    if (hold_vld_q) begin
                        axiov_d = 1'b1;
                        axiol_d = 1'b1;
                        axiod_d = hold_q;
                    end
                    hold_vld_d   = 1'b0;
                    frame_done_d = 1'b1;
                    frame_len_d  = MAX_LEN;
                    err_long_d   = 1'b1;
                    state_d      = DROP;
                end else begin
                    shreg_d = sh_next;
                    dcnt_d  = dcnt_q + 2'd1;
                    if (byte_done) byte_cnt_d = byte_cnt_q + 16'd1;
                    if (beat_done) begin
                        bcnt_d     = 2'd0;
                        hold_d     = sh_next;
                        hold_vld_d = 1'b1;
                        if (hold_vld_q) begin
                            axiov_d = 1'b1;
                            axiod_d = hold_q;
                        end
                    end else begin
                        bcnt_d = bcnt_q + 2'd1;
                    end
                end
            end
            DROP: begin
                if (!bus.crsdv) state_d = IDLE;
            end
            default: state_d = SYNC;
        endcase
    end

    // Register all state and outputs; reset re-enters SYNC with quiet outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= SYNC;
            pcnt_q       <= '0;
            byte_cnt_q   <= 16'd0;
            dcnt_q       <= 2'd0;
            bcnt_q       <= 2'd0;
            shreg_q      <= '0;
            hold_q       <= '0;
            hold_vld_q   <= 1'b0;
            axiov_q      <= 1'b0;
            axiod_q      <= '0;
            axiol_q      <= 1'b0;
            frame_done_q <= 1'b0;
            frame_len_q  <= 16'd0;
            err_pre_q    <= 1'b0;
            err_runt_q   <= 1'b0;
            err_long_q   <= 1'b0;
            err_align_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pcnt_q       <= pcnt_d;
            byte_cnt_q   <= byte_cnt_d;
            dcnt_q       <= dcnt_d;
            bcnt_q       <= bcnt_d;
            shreg_q      <= shreg_d;
            hold_q       <= hold_d;
            hold_vld_q   <= hold_vld_d;
            axiov_q      <= axiov_d;
            axiod_q      <= axiod_d;
            axiol_q      <= axiol_d;
            frame_done_q <= frame_done_d;
            frame_len_q  <= frame_len_d;
            err_pre_q    <= err_pre_d;
            err_runt_q   <= err_runt_d;
            err_long_q   <= err_long_d;
            err_align_q  <= err_align_d;
        end
    end

    assign bus.axiov        = axiov_q;
    assign bus.axiod        = axiod_q;
    assign bus.axiol        = axiol_q;
    assign bus.frame_done   = frame_done_q;
    assign bus.frame_len    = frame_len_q;
    assign bus.err_preamble = err_pre_q;
    assign bus.err_runt     = err_runt_q;
    assign bus.err_long     = err_long_q;
    assign bus.err_align    = err_align_q;
    assign bus.dbg_state    = state_q;
endmodule

// File: tb/tb_ether_rx_framer.sv
// Bench for ether_rx_framer. Three instances share one RMII stimulus:
// 8-bit beats with default limits, 2-bit beats, and 8-bit beats with
// MAX_FRAME_BYTES=4. Each instance has a monitor that checks beats against
// an expected queue and checks the status strobe against an expected record.
module tb_ether_rx_framer;
    logic       clk = 1'b0;
    logic       rst;
    logic       crsdv;
    logic [1:0] rxd;
    int         cyc = 0;
    int         drive_cyc = 0;
    int         n_tests = 0;
    int         n_fail  = 0;

    // Clock and cycle counter.
    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ether_rx_framer_if #(.OUT_WIDTH(8)) if8 ();
    ether_rx_framer_if #(.OUT_WIDTH(2)) if2 ();
    ether_rx_framer_if #(.OUT_WIDTH(8)) ifo ();

    assign if8.crsdv = crsdv;
    assign if8.rxd   = rxd;
    assign if2.crsdv = crsdv;
    assign if2.rxd   = rxd;
    assign ifo.crsdv = crsdv;
    assign ifo.rxd   = rxd;

    ether_rx_framer #(.OUT_WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8));
    ether_rx_framer #(.OUT_WIDTH(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));
    ether_rx_framer #(.OUT_WIDTH(8), .MAX_FRAME_BYTES(4)) u_duto (.clk(clk), .rst(rst), .bus(ifo));

    // Scoreboard state: expected beats are {axiol, axiod}; status is {len, pre, runt, long, align}.
    logic [8:0]  exp8_q[$];
    logic [2:0]  exp2_q[$];
    logic [8:0]  expo_q[$];
    logic [19:0] exp8_stat, exp2_stat, expo_stat;
    logic        chk8 = 1'b0, chk2 = 1'b0, chko = 1'b0;
    int          beats8 = 0, beats2 = 0, beatso = 0;
    int          done8 = 0, done2 = 0, doneo = 0;
    int          first_cyc2 = 0, last_cyc2 = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Monitor for the 8-bit instance.
    always @(posedge clk) begin
        logic [8:0] e;
        #1;
        if (chk8) begin
            if (if8.axiol) check("axiol8_needs_axiov", 32'(if8.axiov), 32'd1);
            if (if8.axiov) begin
                beats8++;
                if (exp8_q.size() > 0) begin
                    e = exp8_q.pop_front();
                    check("beat8", {23'd0, if8.axiol, if8.axiod}, {23'd0, e});
                end
            end
            if (if8.frame_done) begin
                done8++;
                check("stat8", {12'd0, if8.frame_len, if8.err_preamble, if8.err_runt,
                                if8.err_long, if8.err_align}, {12'd0, exp8_stat});
            end else begin
                check("err8_quiet", {28'd0, if8.err_preamble, if8.err_runt,
                                     if8.err_long, if8.err_align}, 32'd0);
            end
        end
    end

    // Monitor for the 2-bit instance, also recording first/last beat cycles.
    always @(posedge clk) begin
        logic [2:0] e;
        #1;
        if (chk2) begin
            if (if2.axiov) begin
                if (beats2 == 0) first_cyc2 = cyc;
                if (if2.axiol) last_cyc2 = cyc;
                beats2++;
                if (exp2_q.size() > 0) begin
                    e = exp2_q.pop_front();
                    check("beat2", {29'd0, if2.axiol, if2.axiod}, {29'd0, e});
                end
            end
            if (if2.frame_done) begin
                done2++;
                check("stat2", {12'd0, if2.frame_len, if2.err_preamble, if2.err_runt,
                                if2.err_long, if2.err_align}, {12'd0, exp2_stat});
            end
        end
    end

    // Monitor for the MAX_FRAME_BYTES=4 instance.
    always @(posedge clk) begin
        logic [8:0] e;
        #1;
        if (chko) begin
            if (ifo.axiov) begin
                beatso++;
                if (expo_q.size() > 0) begin
                    e = expo_q.pop_front();
                    check("beato", {23'd0, ifo.axiol, ifo.axiod}, {23'd0, e});
                end
            end
            if (ifo.frame_done) begin
                doneo++;
                check("stato", {12'd0, ifo.frame_len, ifo.err_preamble, ifo.err_runt,
                                ifo.err_long, ifo.err_align}, {12'd0, expo_stat});
            end
        end
    end

    // Driver tasks: inputs change on the falling edge.
    task automatic drive(input logic c, input logic [1:0] d);
        @(negedge clk);
        drive_cyc = cyc;
        crsdv = c;
        rxd   = d;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 2'b00);
    endtask

    task automatic send_byte(input logic [7:0] b, output int c0);
        c0 = 0;
        for (int j = 0; j < 4; j++) begin
            drive(1'b1, b[2*j +: 2]);
            if (j == 0) c0 = drive_cyc;
        end
    endtask

    // Preamble of npre 01s, an SFD dibit, nbytes bytes base+i, extra 10 dibits, then carrier off.
    task automatic send_frame(input int npre, input logic [1:0] sfd, input int nbytes,
                              input int extra, input logic [7:0] base, output int c0);
        int c;
        c0 = 0;
        for (int i = 0; i < npre; i++) drive(1'b1, 2'b01);
        drive(1'b1, sfd);
        for (int i = 0; i < nbytes; i++) begin
            send_byte(base + 8'(i), c);
            if (i == 0) c0 = c;
        end
        for (int i = 0; i < extra; i++) drive(1'b1, 2'b10);
        drive(1'b0, 2'b00);
    endtask

    task automatic expect8(input int nbeats, input logic [7:0] base);
        logic [7:0] b;
        for (int k = 0; k < nbeats; k++) begin
            b = base + 8'(k);
            exp8_q.push_back({k == nbeats - 1, b});
        end
    endtask

    typedef struct {
        int         npre;
        logic [1:0] sfd;
        int         nbytes;
        int         extra;
        logic [7:0] base;
        int         exp_beats;
        logic [15:0] exp_len;
        logic       e_pre;
        logic       e_runt;
        logic       e_long;
        logic       e_align;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs[NV];

    initial begin
        int c0;
        int b8, d8;
        logic [7:0] bb;
        vecs[0] = '{31, 2'b11,  1, 0, 8'hA5,  1, 16'd1,  1'b0, 1'b1, 1'b0, 1'b0};  // runt 0xA5
        vecs[1] = '{ 8, 2'b11, 64, 0, 8'h00, 64, 16'd64, 1'b0, 1'b0, 1'b0, 1'b0};  // exactly minimum
        vecs[2] = '{ 8, 2'b11, 63, 0, 8'h40, 63, 16'd63, 1'b0, 1'b1, 1'b0, 1'b0};  // one short of minimum
        vecs[3] = '{ 8, 2'b11,  2, 2, 8'h10,  2, 16'd2,  1'b0, 1'b1, 1'b0, 1'b1};  // partial end
        vecs[4] = '{ 5, 2'b11,  0, 0, 8'h00,  0, 16'd0,  1'b1, 1'b0, 1'b0, 1'b0};  // short preamble
        vecs[5] = '{ 1, 2'b10,  0, 0, 8'h00,  0, 16'd0,  1'b1, 1'b0, 1'b0, 1'b0};  // 01 then 10
        vecs[6] = '{ 7, 2'b11,  3, 0, 8'h77,  0, 16'd0,  1'b1, 1'b0, 1'b0, 1'b0};  // one under, data dropped
        vecs[7] = '{ 8, 2'b11,  0, 0, 8'h00,  0, 16'd0,  1'b0, 1'b1, 1'b0, 1'b0};  // zero-beat frame
        vecs[8] = '{ 8, 2'b11,  3, 1, 8'h20,  3, 16'd3,  1'b0, 1'b1, 1'b0, 1'b1};  // one stray dibit
        vecs[9] = '{20, 2'b11,  5, 0, 8'hC3,  5, 16'd5,  1'b0, 1'b1, 1'b0, 1'b0};  // long preamble

        rst   = 1'b1;
        crsdv = 1'b0;
        rxd   = 2'b00;
        repeat (3) @(negedge clk);
        check("rst_outputs", {if8.axiov, if8.axiol, if8.frame_done, if8.err_preamble, if8.err_runt,
                              if8.err_long, if8.err_align, 9'd0, if8.frame_len}, 32'd0);
        check("rst_axiod", 32'(if8.axiod), 32'd0);
        check("rst_state", 32'(if8.dbg_state), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("sync_to_idle", 32'(if8.dbg_state), 32'd1);

        // Table-driven frames on the 8-bit instance.
        chk8 = 1'b1;
        for (int i = 0; i < NV; i++) begin
            b8 = beats8;
            d8 = done8;
            exp8_stat = {vecs[i].exp_len, vecs[i].e_pre, vecs[i].e_runt, vecs[i].e_long, vecs[i].e_align};
            expect8(vecs[i].exp_beats, vecs[i].base);
            send_frame(vecs[i].npre, vecs[i].sfd, vecs[i].nbytes, vecs[i].extra, vecs[i].base, c0);
            idle(3);
            check($sformatf("v%0d_beats", i), 32'(beats8 - b8), 32'(vecs[i].exp_beats));
            check($sformatf("v%0d_done", i), 32'(done8 - d8), 32'd1);
        end

        // Back-to-back frames separated by a single idle cycle.
        b8 = beats8;
        d8 = done8;
        exp8_stat = {16'd2, 1'b0, 1'b1, 1'b0, 1'b0};
        expect8(2, 8'h61);
        send_frame(8, 2'b11, 2, 0, 8'h61, c0);
        expect8(2, 8'h61);
        send_frame(8, 2'b11, 2, 0, 8'h61, c0);
        idle(3);
        check("b2b_beats", 32'(beats8 - b8), 32'd4);
        check("b2b_done", 32'(done8 - d8), 32'd2);
        chk8 = 1'b0;

        // 64-byte frame on the 2-bit instance: one beat per cycle.
        chk2 = 1'b1;
        exp2_stat = {16'd64, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 64; i++) begin
            bb = 8'(i);
            for (int j = 0; j < 4; j++) exp2_q.push_back({(i == 63 && j == 3), bb[2*j +: 2]});
        end
        send_frame(8, 2'b11, 64, 0, 8'h00, c0);
        idle(3);
        check("w2_beats", 32'(beats2), 32'd256);
        check("w2_done", 32'(done2), 32'd1);
        check("w2_first_latency", 32'(first_cyc2 - c0), 32'd2);
        check("w2_span", 32'(last_cyc2 - first_cyc2), 32'd255);
        chk2 = 1'b0;

        // Overflow at four bytes, then a normal frame on the same instance.
        chko = 1'b1;
        expo_stat = {16'd4, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 4; k++) begin
            bb = 8'h30 + 8'(k);
            expo_q.push_back({k == 3, bb});
        end
        send_frame(8, 2'b11, 6, 0, 8'h30, c0);
        idle(3);
        check("ovf_beats", 32'(beatso), 32'd4);
        check("ovf_done", 32'(doneo), 32'd1);
        expo_stat = {16'd3, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 3; k++) begin
            bb = 8'h50 + 8'(k);
            expo_q.push_back({k == 2, bb});
        end
        send_frame(8, 2'b11, 3, 0, 8'h50, c0);
        idle(3);
        check("ovf_next_beats", 32'(beatso), 32'd7);
        check("ovf_next_done", 32'(doneo), 32'd2);
        chko = 1'b0;

        // Reset during byte 10; a clean-looking frame follows with the carrier still high.
        for (int i = 0; i < 8; i++) drive(1'b1, 2'b01);
        drive(1'b1, 2'b11);
        for (int i = 0; i < 9; i++) send_byte(8'h55, c0);
        drive(1'b1, 2'b01);
        drive(1'b1, 2'b01);
        b8 = beats8;
        d8 = done8;
        @(negedge clk);
        chk8 = 1'b1;
        rst  = 1'b1;
        rxd  = 2'b01;
        drive(1'b1, 2'b01);
        rst = 1'b0;
        drive(1'b1, 2'b01);
        check("rst_mid_sync_hold", 32'(if8.dbg_state), 32'd0);
        for (int i = 0; i < 9; i++) drive(1'b1, 2'b01);
        drive(1'b1, 2'b11);
        for (int i = 0; i < 3; i++) send_byte(8'hE0 + 8'(i), c0);
        drive(1'b0, 2'b00);
        idle(2);
        check("rst_mid_no_beats", 32'(beats8 - b8), 32'd0);
        check("rst_mid_no_done", 32'(done8 - d8), 32'd0);
        exp8_stat = {16'd4, 1'b0, 1'b1, 1'b0, 1'b0};
        expect8(4, 8'h90);
        send_frame(8, 2'b11, 4, 0, 8'h90, c0);
        idle(3);
        check("rst_next_beats", 32'(beats8 - b8), 32'd4);
        check("rst_next_done", 32'(done8 - d8), 32'd1);
        chk8 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ether_rx_framer.md
# ether_rx_framer

Parametrised RMII receive framer: it sits directly behind the RMII pins (50 MHz `crsdv`/`rxd`) and ahead of the MAC parsing logic. It hunts for preamble/SFD and assembles payload dibits into OUT_WIDTH-bit AXI-style beats. It marks the last beat of each frame and reports per-frame length and error status. It replaces the fixed 2-bit receiver and adds configurable preamble tolerance, beat width, length policing and clean re-sync after reset.

## Interface
- `OUT_WIDTH`, default 8: payload beat width in bits; legal values 2, 4, 8. DPB (dibits per beat) = OUT_WIDTH/2.
- `PREAMBLE_MIN`, default 8: minimum consecutive `01` dibits required before an SFD `11` is accepted.
- `MIN_FRAME_BYTES`, default 64: frames shorter than this set `err_runt`.
- `MAX_FRAME_BYTES`, default 1522: byte limit, legal range 1..65534. Exceeding it truncates the frame and sets `err_long`.

Ports:
- `clk` input 1: 50 MHz RMII reference clock.
- `rst` input 1: reset; **synchronous, active-high**.
- `crsdv` input 1: RMII carrier sense / data valid.
- `rxd` input 2: RMII receive dibit; the first dibit of a byte is byte bits [1:0] (LSB first).
- `axiov` output 1: payload beat valid.
- `axiod` output OUT_WIDTH: payload beat; the earliest dibit is in bits [1:0].
- `axiol` output 1: last beat of frame; only ever high together with `axiov`.
- `frame_done` output 1: one-cycle end-of-frame status strobe.
- `frame_len` output 16: bytes received (whole bytes only). Valid when `frame_done` is high; holds otherwise.
- `err_preamble` output 1: preamble/SFD violation. Valid with `frame_done`.
- `err_runt` output 1: `frame_len` < MIN_FRAME_BYTES. Valid with `frame_done`.
- `err_long` output 1: frame truncated at MAX_FRAME_BYTES. Valid with `frame_done`.
- `err_align` output 1: frame ended with a partial beat or partial byte. Valid with `frame_done`.

## Operation
- All outputs are registered. Reset value of every output is 0. Reset enters SYNC.
- State machine (states SYNC, IDLE, PREAMBLE, DATA, DROP):
  - **SYNC**: wait for `crsdv`=0, then go to IDLE. This prevents locking onto mid-frame data after reset.
  - **IDLE**: on `crsdv`=1 and `rxd`=01, go to PREAMBLE with pcnt=1. `rxd`=00 stays in IDLE. Any other `rxd` goes to DROP, with no strobe.
  - **PREAMBLE**:
    - `crsdv`=0: go to IDLE silently.
    - `rxd`=01: pcnt increments, saturating at PREAMBLE_MIN.
    - `rxd`=11 with pcnt ≥ PREAMBLE_MIN: go to DATA; clear the byte counter, the dibit counter and the hold register.
    - Any other case: `frame_done`=1 with `err_preamble`=1 and `frame_len`=0, then go to DROP.
  - **DATA**, while `crsdv`=1:
    - Shift `rxd` into the beat assembler.
    - Each 4th dibit increments the byte count.
    - When DPB dibits have accumulated, the beat is complete. A previously held beat is emitted (`axiov`=1, `axiol`=0), and the new beat enters the hold register.
  - **DATA end**, on `crsdv`=0:
    - If a held beat exists, emit it with `axiol`=1.
    - Strobe `frame_done` with final status.
    - Discard any partial beat and set `err_align` if one existed or if the dibit count mod 4 ≠ 0.
    - Go to IDLE.
  - **DATA overflow**: if completing a byte would make the count exceed MAX_FRAME_BYTES, that byte is not counted and its beat is not stored. The held beat is emitted with `axiol`=1. `frame_done` fires with `err_long`=1 and `frame_len`=MAX_FRAME_BYTES, then go to DROP.
  - **DROP**: wait for `crsdv`=0, then go to IDLE.
- `err_runt` is evaluated only at a normal DATA end: `frame_len` < MIN_FRAME_BYTES, including 0.
- Zero-beat frame (SFD immediately followed by `crsdv`=0): `frame_done`=1, `frame_len`=0, `err_runt`=1, `axiov` stays 0.
- The byte counter is 16 bits. All error flags are 0 whenever `frame_done` is 0.

## Timing
- Input sampled at edge k; a beat completing at edge k enters hold at edge k.
- A held beat is driven on `axiod`/`axiov` from the edge at which the next beat completes, or at which frame end or overflow is detected. Output latency is therefore DPB cycles during a frame, and 1 cycle for the final beat after `crsdv` falls.
- `axiov` is high for exactly one cycle per beat. There is no backpressure; the consumer must accept every beat.
- `frame_done` rises in the same cycle as the `axiol` beat, or alone when there is no beat.
- Back-to-back frames: `crsdv` low for 1 cycle between frames suffices. IDLE accepts `01` on the very next cycle.
- Reset mid-frame: outputs drop to 0 at the next edge with no `axiol`/`frame_done` for the aborted frame. The rest of that frame is ignored via SYNC.

## Test plan
- **Runt frame, OUT_WIDTH=8.** Stimulus: 31×`01`, `11`, then dibits 01,01,10,10 (0xA5), then `crsdv` low. Required: a single beat `axiod`=0xA5 with `axiov`=`axiol`=1, and `frame_done` with `frame_len`=1, `err_runt`=1, other errors 0.
- **64-byte frame, OUT_WIDTH=2.** Stimulus: 64 bytes 0x00..0x3F. Required:
  - 256 beats, one per cycle; the first beat is 0 one cycle after the first data dibit.
  - `axiol` is on beat 256 only.
  - `frame_len`=64, no errors.
- **Preamble faults.** Stimulus (a): 5×`01` then `11` with PREAMBLE_MIN=8. Stimulus (b): `01`,`10`. Required: `frame_done` with `err_preamble`=1 and `frame_len`=0, no `axiov`; DROP until `crsdv` low; the next good frame is received normally.
- **Overflow, MAX_FRAME_BYTES=4.** Stimulus: a 6-byte frame. Required: 4 beats (OUT_WIDTH=8), the 4th carrying `axiol`; `frame_len`=4, `err_long`=1; no further beats.
- **Partial end.** Stimulus: 2 bytes plus 2 extra dibits (OUT_WIDTH=8). Required: 2 beats, `frame_len`=2, `err_align`=1, `err_runt`=1.
- **Reset mid-frame.** Stimulus: assert `rst` during byte 10 while `crsdv` stays high with data `01` patterns present. Required: no beats and no strobe until `crsdv` has been low for ≥1 cycle; the following frame is received intact.
